div_scheduler: RTL and testbench

Shared sequential divider with a two-port round-robin front end. Two requesters issue unsigned WIDTH-bit divide operations over valid/ready handshakes. The block grants one requester at a time and runs a restoring divider, one quotient bit per cycle. It returns quotient, remainder, divide-by-zero flag and requester ID on a single response channel. It replaces per-client combinational dividers in the ALU area with one time-shared unit.

---
 rtl/div_scheduler.sv | 118 +++++++++++
 tb/tb_div_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// Time-shared restoring divider behind a two-requester round-robin front end.
// Produces one quotient bit per cycle; the response is held until the consumer accepts it.
module div_scheduler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_req1_ready,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_id,
    output logic [WIDTH-1:0] o_resp_q,
    output logic [WIDTH-1:0] o_resp_r,
    output logic             o_resp_dz
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              r_last;
    logic [WIDTH-1:0]  r_rem, r_quo, r_b;
    logic [CntW-1:0]   r_cnt;
    logic              r_id, r_dz, r_resp_valid;

    logic              w_idle, w_gnt0, w_gnt1, w_accept, w_fits;
    logic [WIDTH-1:0]  w_sel_a, w_sel_b, w_diff;
    logic [WIDTH:0]    w_shift;

    // r_last == 1 means requester 1 won last, so requester 0 takes the first tie after reset.
    assign w_idle   = (r_state == StIdle) && !i_rst;
    assign w_gnt0   = w_idle && i_req0_valid && (!i_req1_valid || r_last);
    assign w_gnt1   = w_idle && i_req1_valid && (!i_req0_valid || !r_last);
    assign w_accept = w_gnt0 || w_gnt1;
    assign w_sel_a  = w_gnt1 ? i_req1_a : i_req0_a;
    assign w_sel_b  = w_gnt1 ? i_req1_b : i_req0_b;

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // Remainder stays below B, so the low WIDTH bits of the difference are exact when it fits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = w_shift >= {1'b0, r_b};
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = (w_sel_b == '0) ? StDone : StDiv;
                end
            end
            StDiv: begin
                if (r_cnt == '0) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (i_resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_last       <= 1'b1;
            r_rem        <= '0;
            r_quo        <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_dz         <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_resp_valid <= (w_state_d == StDone);
            if (w_accept) begin
                r_last <= w_gnt1;
                r_id   <= w_gnt1;
                r_b    <= w_sel_b;
                if (w_sel_b == '0) begin
                    r_quo <= '1;
                    r_rem <= w_sel_a;
                    r_dz  <= 1'b1;
                end else begin
                    r_quo <= w_sel_a;
                    r_rem <= '0;
                    r_dz  <= 1'b0;
                    r_cnt <= CntW'(WIDTH - 1);
                end
            end else if (r_state == StDiv) begin
                r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_id    = r_id;
    assign o_resp_q     = r_quo;
    assign o_resp_r     = r_rem;
    assign o_resp_dz    = r_dz;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: directed operations with literal expectations plus a
// cycle-level model of the arbiter/divider that checks every output each cycle.
module tb_div_scheduler;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0, rr = 1'b1;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rdy0, rdy1, rv, rid, rdz;
    logic [W-1:0] rq, rrm;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    div_scheduler #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0_valid(v0),
        .i_req0_a    (a0),
        .i_req0_b    (b0),
        .o_req0_ready(rdy0),
        .i_req1_valid(v1),
        .i_req1_a    (a1),
        .i_req1_b    (b1),
        .o_req1_ready(rdy1),
        .o_resp_valid(rv),
        .i_resp_ready(rr),
        .o_resp_id   (rid),
        .o_resp_q    (rq),
        .o_resp_r    (rrm),
        .o_resp_dz   (rdz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 = waiting for work, 1 = computing, 2 = holding a response.
    int           m_phase = 0;
    int           m_cnt = 0;
    bit           m_init = 0, m_fresh = 0, m_last = 1;
    logic [W-1:0] m_q = '0, m_r = '0;
    logic         m_id = 0, m_dz = 0;

    always @(negedge clk) begin
        bit           e0, e1;
        logic [W-1:0] a, b;
        if (rst) begin
            if (m_init) begin
                chk("m_rst_rdy0", 32'(rdy0), 0);
                chk("m_rst_rdy1", 32'(rdy1), 0);
            end
            m_init = 1; m_phase = 0; m_last = 1; m_fresh = 1;
            m_q = '0; m_r = '0; m_id = 0; m_dz = 0;
        end else if (m_init) begin
            e0 = (m_phase == 0) && v0 && (!v1 || m_last);
            e1 = (m_phase == 0) && v1 && (!v0 || !m_last);
            chk("m_rdy0", 32'(rdy0), 32'(e0));
            chk("m_rdy1", 32'(rdy1), 32'(e1));
            chk("m_valid", 32'(rv), 32'(m_phase == 2));
            if (m_phase == 2 || m_fresh) begin
                chk("m_q", 32'(rq), 32'(m_q));
                chk("m_r", 32'(rrm), 32'(m_r));
                chk("m_id", 32'(rid), 32'(m_id));
                chk("m_dz", 32'(rdz), 32'(m_dz));
            end
            case (m_phase)
                0: if (e0 || e1) begin
                    a = e1 ? a1 : a0;
                    b = e1 ? b1 : b0;
                    m_last = e1; m_id = e1; m_fresh = 0;
                    if (b == 0) begin
                        m_phase = 2; m_q = '1; m_r = a; m_dz = 1;
                    end else begin
                        m_phase = 1; m_cnt = W; m_q = a / b; m_r = a % b; m_dz = 0;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (rr) m_phase = 0;
            endcase
        end
    end

    task automatic wait_accept(input int port, output int n);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if ((port == 0 && rdy0) || (port == 1 && rdy1)) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("accept_seen", 32'(got), 1);
        n = cyc;
    endtask

    task automatic wait_resp(input int n, output int lat);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rv) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("resp_seen", 32'(got), 1);
        lat = cyc - n;
    endtask

    task automatic op(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                      input int elat);
        int n, lat;
        if (port == 0) begin v0 = 1; a0 = a; b0 = b; end
        else begin v1 = 1; a1 = a; b1 = b; end
        wait_accept(port, n);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        wait_resp(n, lat);
        chk("latency", 32'(lat), 32'(elat));
        chk("lit_q", 32'(rq), 32'(eq));
        chk("lit_r", 32'(rrm), 32'(er));
        chk("lit_dz", 32'(rdz), 32'(edz));
        chk("lit_id", 32'(rid), 32'(port));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, lat, ng;
        int gid[4], gcyc[4];

        // Reset with both requesters valid: neither may be acknowledged.
        v0 = 1; v1 = 1; a0 = 9; b0 = 3; a1 = 9; b1 = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rv), 0);
        chk("rst_q", 32'(rq), 0);
        chk("rst_r", 32'(rrm), 0);
        chk("rst_rdy0", 32'(rdy0), 0);
        @(posedge clk); #1;
        v0 = 0; v1 = 0; rst = 0;
        @(posedge clk); #1;

        op(0, 25, 5, 5, 0, 0, 9);
        op(0, 25, 6, 4, 1, 0, 9);
        op(0, 255, 52, 4, 47, 0, 9);
        op(1, 128, 33, 3, 29, 0, 9);
        op(0, 0, 1, 0, 0, 0, 9);
        op(1, 255, 1, 255, 0, 0, 9);
        op(1, 7, 200, 0, 7, 0, 9);
        op(1, 114, 0, 255, 114, 1, 1);

        // Arbitration from a fresh reset with both requesters always valid.
        rst = 1; @(posedge clk); #1; rst = 0;
        a0 = 100; b0 = 7; a1 = 200; b1 = 9; v0 = 1; v1 = 1;
        ng = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (rdy0) begin gid[ng] = 0; gcyc[ng] = cyc; ng++; end
            else if (rdy1) begin gid[ng] = 1; gcyc[ng] = cyc; ng++; end
            @(posedge clk); #1;
        end
        v0 = 0; v1 = 0;
        chk("arb_count", 32'(ng), 4);
        if (ng == 4) begin
            chk("arb_g0", 32'(gid[0]), 0);
            chk("arb_g1", 32'(gid[1]), 1);
            chk("arb_g2", 32'(gid[2]), 0);
            chk("arb_g3", 32'(gid[3]), 1);
            for (int i = 1; i < 4; i++) chk("arb_gap", 32'(gcyc[i] - gcyc[i-1]), 10);
        end
        repeat (12) @(posedge clk);
        #1;

        // Backpressure: response held, late request on port 1 waits for IDLE.
        rr = 0; v0 = 1; a0 = 200; b0 = 3;
        wait_accept(0, n);
        @(posedge clk); #1;
        v0 = 0; v1 = 1; a1 = 9; b1 = 3;
        wait_resp(n, lat);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 32'(rv), 1);
            chk("bp_q", 32'(rq), 66);
            chk("bp_r", 32'(rrm), 2);
            chk("bp_rdy1", 32'(rdy1), 0);
            @(posedge clk); #1;
        end
        rr = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drop", 32'(rv), 0);
        chk("bp_idle_rdy1", 32'(rdy1), 1);
        @(posedge clk); #1;
        v1 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Reset in cycle N+4 of a 128/32 divide.
        v0 = 1; a0 = 128; b0 = 32;
        wait_accept(0, n);
        @(posedge clk); #1;
        v0 = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mid_valid", 32'(rv), 0);
        chk("mid_q", 32'(rq), 0);
        chk("mid_r", 32'(rrm), 0);
        chk("mid_id", 32'(rid), 0);
        chk("mid_dz", 32'(rdz), 0);
        @(posedge clk); #1;
        v0 = 1; v1 = 1; a1 = 50; b1 = 5;
        @(negedge clk);
        chk("mid_tie_rdy0", 32'(rdy0), 1);
        chk("mid_tie_rdy1", 32'(rdy1), 0);
        n = cyc;
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        wait_resp(n, lat);
        chk("mid_lat", 32'(lat), 9);
        chk("mid_res_q", 32'(rq), 4);
        chk("mid_res_r", 32'(rrm), 0);
        chk("mid_res_id", 32'(rid), 0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
